// File: rtl/bus_regslave.sv
// Register-bank slave endpoint for the matrix bus: a two-phase pipelined responder
// with programmable wait states and an error response for unaligned or out-of-range accesses.
module bus_regslave #(
  parameter int unsigned addrwidth    = 32,
  parameter int unsigned datawidth_p  = 32,
  parameter int unsigned tranwidth_p  = 2,
  parameter int unsigned depth_p      = 16,
  parameter int unsigned waitstates_p = 0
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_i,
  input  logic [tranwidth_p-1:0] bus_trans_i,
  input  logic [addrwidth-1:0]   bus_addr_i,
  input  logic                   bus_write_i,
  input  logic [datawidth_p-1:0] bus_wdata_i,
  output logic                   bus_ready_o,
  output logic                   bus_resp_o,
  output logic [datawidth_p-1:0] bus_rdata_o
);

  localparam int unsigned ByteBits = $clog2(datawidth_p / 8);
  localparam int unsigned IdxW     = $clog2(depth_p);
  localparam logic [addrwidth-1:0] AlignMask = addrwidth'((64'd1 << ByteBits) - 64'd1);

  typedef enum logic [1:0] {StIdle, StWait, StData} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic [datawidth_p-1:0] regs_q [depth_p];
  logic [datawidth_p-1:0] regs_d [depth_p];

  logic            accept;
  logic            addr_err;
  logic [IdxW-1:0] addr_idx;

  assign bus_ready_o = (state_q != StWait);
  assign accept      = bus_ready_o &&
                       ((bus_trans_i == tranwidth_p'(2)) || (bus_trans_i == tranwidth_p'(3)));
  assign addr_idx    = IdxW'(bus_addr_i >> ByteBits);
  assign addr_err    = (|(bus_addr_i & AlignMask)) || (|(bus_addr_i >> (ByteBits + IdxW)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    regs_d  = regs_q;

    unique case (state_q)
      StIdle, StData: begin
        if (state_q == StData && write_q && !err_q) begin
          regs_d[idx_q] = bus_wdata_i;
        end
        if (accept) begin
          idx_d   = addr_idx;
          write_d = bus_write_i;
          err_d   = addr_err;
          cnt_d   = 4'd0;
          state_d = (waitstates_p > 0) ? StWait : StData;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        // The final WAIT cycle is the one where the counter reaches waitstates_p-1.
        if (cnt_q == 4'(waitstates_p - 1)) begin
          cnt_d   = 4'd0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_resp_o  = 1'b0;
    bus_rdata_o = '0;
    if (state_q == StData) begin
      bus_resp_o = err_q;
      if (!write_q && !err_q) begin
        bus_rdata_o = regs_q[idx_q];
      end
    end
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(depth_p); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: doc/bus_regslave.md
Name: bus_regslave

Overview:
- Slave-side responder for the matrix bus: the endpoint attached to a matrix slave port. It receives trans/addr/write/wdata and returns ready/resp/rdata.
- Implements a bank of depth_p word-wide read/write registers, plus a programmable number of wait states.
- Flags accesses that are out of range or unaligned with an error response.
- Serves as the standard register endpoint behind the matrix and as a bus-model target in matrix tests.

Parameters:
addrwidth, 32, address bus width
datawidth_p, 32, data bus width (multiple of 8, power of two)
tranwidth_p, 2, transfer-type width
depth_p, 16, number of registers (power of two, >=2)
waitstates_p, 0, ready-low cycles inserted in every data phase (0..15)

Ports:
main_clk_i  input  1  clock, all logic on rising edge
main_rst_i  input  1  reset: synchronous and active-high
bus_trans_i  input  tranwidth_p  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
bus_addr_i  input  addrwidth  byte address (address phase)
bus_write_i  input  1  1=write, 0=read (address phase)
bus_wdata_i  input  datawidth_p  write data (data phase)
bus_ready_o  output  1  transfer completes / slave ready
bus_resp_o  output  1  0=OKAY, 1=ERROR, valid when ready_o=1
bus_rdata_o  output  datawidth_p  read data, valid when ready_o=1 in a read data phase

Behaviour:
- Reset (main_rst_i=1 at clock edge): ready_o=1, resp_o=0, rdata_o=0, all registers 0, FSM IDLE, wait counter 0. Reset overrides everything, including a pending data phase; a pending write is discarded.
- Two-phase pipelined protocol:
  - An address phase is accepted in any cycle where ready_o=1 and trans_i is 2 or 3. addr, write and the error flag are captured.
  - trans_i of 0 or 1 is not a transfer and produces no data phase.
- Address decode:
  - B = log2(datawidth_p/8). Register index = addr_i[B+log2(depth_p)-1:B].
  - Error if addr_i[B-1:0] != 0, or if any bit above B+log2(depth_p)-1 is set.
- FSM:
  - IDLE: ready_o=1, resp_o=0. On accept: go to WAIT if waitstates_p>0, otherwise go to DATA.
  - WAIT: ready_o=0, resp_o=0, counter counts up to waitstates_p. Move to DATA after waitstates_p cycles in WAIT.
  - DATA: ready_o=1 for exactly one cycle, and the transfer completes in this cycle.
    - Write: register updated with wdata_i at the end of this cycle (error: no update).
    - Read: rdata_o = register value (error: rdata_o=0).
    - resp_o = error flag.
    - In the same cycle a new address phase may be accepted: DATA then moves to WAIT/DATA again; otherwise it returns to IDLE.
- Latency:
  - Zero wait states: data phase completes 1 cycle after the address phase, and back-to-back transfers reach full throughput.
  - Otherwise: completion occurs waitstates_p+1 cycles after the address phase.
- rdata_o=0 and resp_o=0 in every cycle that is not a DATA cycle, and during write DATA cycles.
- Write followed by read of the same address back-to-back: the read returns the new value, because the write commits before the read's data phase.
- trans_i/addr_i sampled while ready_o=0 are ignored. The master must hold them; the slave does not need to check this.
- Error response is single-cycle: resp_o=1 together with ready_o=1.
- Bits of addr_i below B are only used for the alignment check.

Test Plan:
- Defaults, reset then idle: ready_o=1, resp_o=0, rdata_o=0 for 10 cycles with trans=0 and trans=1; no register changes.
- Defaults, write 0xDEADBEEF to addr 0x08, then immediately read 0x08 (NONSEQ, back-to-back) -> the read data phase returns rdata_o=0xDEADBEEF, resp_o=0, and ready_o stays 1 throughout.
- Defaults, read addr 0x40 (out of range) and write addr 0x06 (unaligned) -> resp_o=1 with ready_o=1 in each data phase, rdata_o=0; a follow-up read of 0x04 returns its old value.
- waitstates_p=3, write 0x12345678 to 0x3C, then read 0x3C -> ready_o low for exactly 3 cycles per transfer; read completes with 0x12345678 on the 4th cycle after its address phase.
- waitstates_p=2: assert main_rst_i during WAIT of a write to 0x00 -> the next cycle has ready_o=1 and resp_o=0; a later read of 0x00 returns 0.
- Defaults, burst of 16 SEQ writes to 0x00..0x3C with data=index, then 16 reads -> every read returns its index and no ready_o low cycle appears.
